mdu_issue_ctrl: RTL and testbench

- Sequences the multiply/divide unit (MDU) on behalf of the EX stage.
- Latches MDU operations, drives the MDU's start pulse, control code and operands, and tracks each operation to completion.
- Holds a one-deep pending buffer so one MDU op can queue behind a busy MDU without stalling.
- Generates the pipeline stall for mfhi/mflo and for buffer-full, and flags an MDU that stays busy beyond its expected latency.

---
 rtl/mdu_issue_ctrl_pkg.sv | 40 ++++
 rtl/mdu_issue_ctrl_pend_buf.sv | 48 ++++
 rtl/mdu_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared definitions for the MDU issue controller: op codes (common with the
// MDU and the decoder), FSM state encodings, the op/operand bundle and helpers.
package mdu_issue_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MTHI  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // One MDU operation as it travels through the buffer and issue registers.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } mdu_req_t;

  // mult/multu/div/divu occupy the MDU for several cycles; mtlo/mthi do not.
  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_issue_ctrl_pend_buf.sv
// One-entry pending buffer holding an MDU op that arrived while the MDU was
// occupied. Flush drops the entry; a load in the same cycle as a clear keeps
// the buffer full with the newly loaded op.
module mdu_pend_buf
  import mdu_issue_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     clear,
  input  logic     flush,
  input  mdu_req_t load_req,
  output logic     valid,
  output mdu_req_t req
);

  logic     valid_q, valid_d;
  mdu_req_t req_q, req_d;

  // Next-state: flush beats load, load beats clear (pop and refill together).
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      req_d   = load_req;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign valid = valid_q;
  assign req   = req_q;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// MDU issue controller for the EX stage: latches MDU ops, pulses the MDU
// start with a stable control code and operands, tracks mult/div to
// completion, queues one op behind a busy MDU, stalls the pipe for
// mfhi/mflo and a full buffer, and flags an MDU that overstays its latency.
//
// Request handshake: the EX stage offers an op with req_valid; stall acts as
// the not-ready signal. An op is taken on the rising edge where
// req_valid=1, flush=0 and stall=0, and the EX stage must hold req_* stable
// until that edge. flush withdraws any offer for that cycle.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES   = 5,
  parameter int unsigned DIV_CYCLES    = 10,
  parameter int unsigned TIMEOUT_SLACK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic              rd_hilo,
  input  logic              flush,
  input  logic              mdu_busy,
  output logic              mdu_start,
  output logic [OP_W-1:0]   mdu_ctrl,
  output logic [DATA_W-1:0] mdu_srca,
  output logic [DATA_W-1:0] mdu_srcb,
  output logic              stall,
  output logic              pend_valid,
  output logic              op_done,
  output logic              err_timeout,
  output logic [1:0]        dbg_state
);

  // Counter loads; the counter is 5 bits, so DIV_CYCLES + TIMEOUT_SLACK <= 31.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES + TIMEOUT_SLACK);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES + TIMEOUT_SLACK);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_first_q, run_first_d;
  logic             start_q, start_d;
  mdu_req_t         iss_q, iss_d;
  logic             op_done_q, op_done_d;
  logic             err_q, err_d;

  logic             buf_valid;
  mdu_req_t         buf_req;
  logic             buf_load;
  logic             buf_clear;

  logic             run_done;
  logic             retire;
  logic             accept;
  mdu_req_t         new_req;

  assign new_req = '{op: req_op, a: req_a, b: req_b};

  mdu_pend_buf u_pend_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .clear    (buf_clear),
    .flush    (flush),
    .load_req (new_req),
    .valid    (buf_valid),
    .req      (buf_req)
  );

  // Retire detection, stall and acceptance. Busy is ignored in the first RUN
  // cycle because the MDU raises it one edge after the start pulse. An mtlo
  // or mthi retires in its single ISSUE cycle.
  always_comb begin
    run_done = (state_q == ST_RUN) && !run_first_q && !mdu_busy;
    retire   = run_done || ((state_q == ST_ISSUE) && !is_muldiv(iss_q.op));
    stall    = (rd_hilo && ((state_q != ST_IDLE) || buf_valid)) ||
               (req_valid && buf_valid && !retire);
    accept   = req_valid && !flush && !stall;
  end

  // Next-state, counter, error and buffer control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_first_d = 1'b0;
    iss_d       = iss_q;
    op_done_d   = 1'b0;
    err_d       = err_q;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          iss_d   = new_req;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (is_muldiv(iss_q.op)) begin
          cnt_d       = is_div(iss_q.op) ? DIV_LOAD : MULT_LOAD;
          run_first_d = 1'b1;
          state_d     = ST_RUN;
          buf_load    = accept;
        end
      end
      ST_RUN: begin
        cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        // Counter reaches zero with the MDU still busy: latch the error and
        // keep waiting for busy to drop.
        if (mdu_busy && (cnt_q <= CNT_W'(1))) begin
          err_d = 1'b1;
        end
        if (run_done) begin
          op_done_d = 1'b1;
        end else begin
          buf_load = accept;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // On retire the next op comes from the buffer first (FIFO order), else
    // straight from a request accepted this cycle. A flushed buffer entry is
    // never issued.
    if (retire) begin
      if (buf_valid && !flush) begin
        iss_d     = buf_req;
        buf_clear = 1'b1;
        buf_load  = accept;
        state_d   = ST_ISSUE;
      end else if (accept) begin
        iss_d   = new_req;
        state_d = ST_ISSUE;
      end else begin
        state_d = ST_IDLE;
      end
    end
    start_d = (state_d == ST_ISSUE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      run_first_q <= 1'b0;
      start_q     <= 1'b0;
      iss_q       <= '0;
      op_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_first_q <= run_first_d;
      start_q     <= start_d;
      iss_q       <= iss_d;
      op_done_q   <= op_done_d;
      err_q       <= err_d;
    end
  end

  assign mdu_start   = start_q;
  assign mdu_ctrl    = iss_q.op;
  assign mdu_srca    = iss_q.a;
  assign mdu_srcb    = iss_q.b;
  assign pend_valid  = buf_valid;
  assign op_done     = op_done_q;
  assign err_timeout = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl with a behavioural MDU (busy timing and hi/lo)
// and an issue scoreboard checking order, control code and operands.
module tb_mdu_issue_ctrl;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rd_hilo = 1'b0;
  logic        flush = 1'b0;
  logic        mdu_busy;
  logic        mdu_start;
  logic [2:0]  mdu_ctrl;
  logic [31:0] mdu_srca;
  logic [31:0] mdu_srcb;
  logic        stall;
  logic        pend_valid;
  logic        op_done;
  logic        err_timeout;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int starts = 0;
  int dones = 0;
  int cyc = 0;
  logic [66:0] exp_q[$];
  int start_cyc_q[$];
  int done_cyc_q[$];

  mdu_issue_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .rd_hilo(rd_hilo), .flush(flush),
    .mdu_busy(mdu_busy), .mdu_start(mdu_start), .mdu_ctrl(mdu_ctrl),
    .mdu_srca(mdu_srca), .mdu_srcb(mdu_srcb), .stall(stall),
    .pend_valid(pend_valid), .op_done(op_done), .err_timeout(err_timeout),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural MDU ----------------
  logic        model_busy;
  logic        force_busy = 1'b0;
  int          bcnt;
  logic [31:0] hi, lo;
  logic [63:0] res;

  assign mdu_busy = model_busy | force_busy;

  function automatic logic [63:0] mdu_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    case (op)
      3'd0: r = 64'(longint'($signed(a)) * longint'($signed(b)));
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      3'd3: if (b != 0) r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_busy <= 1'b0; bcnt <= 0; hi <= '0; lo <= '0; res <= '0;
    end else if (mdu_start) begin
      if (mdu_ctrl <= 3'd3) begin
        model_busy <= 1'b1;
        bcnt <= (mdu_ctrl >= 3'd2) ? DIV_CYCLES : MULT_CYCLES;
        res <= mdu_result(mdu_ctrl, mdu_srca, mdu_srcb);
      end else if (mdu_ctrl == 3'd4) begin
        lo <= mdu_srca;
      end else if (mdu_ctrl == 3'd5) begin
        hi <= mdu_srca;
      end
    end else if (model_busy) begin
      if (bcnt == 1) begin
        model_busy <= 1'b0;
        hi <= res[63:32];
        lo <= res[31:0];
      end
      bcnt <= bcnt - 1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (reset === 1'b1 && mdu_start === 1'b1) begin
      logic [66:0] e;
      starts++;
      start_cyc_q.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_start got ctrl=%0d a=%h b=%h, expected no start", mdu_ctrl, mdu_srca, mdu_srcb);
      end else begin
        e = exp_q.pop_front();
        if ({mdu_ctrl, mdu_srca, mdu_srcb} !== e) begin
          fails++;
          $display("FAIL sb_issue got ctrl=%0d a=%h b=%h, expected ctrl=%0d a=%h b=%h",
                   mdu_ctrl, mdu_srca, mdu_srcb, e[66:64], e[63:32], e[31:0]);
        end
      end
    end
    if (reset === 1'b1 && op_done === 1'b1) begin
      dones++;
      done_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver ----------------
  task automatic send_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int waited);
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    #1;
    while (stall === 1'b1 && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    if (stall !== 1'b0) begin
      tests++; fails++;
      $display("FAIL send_accept got stall=%b, expected 0 within 100 cycles", stall);
    end else begin
      exp_q.push_back({op, a, b});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); #1;
    tests++;
    if ({mdu_start, mdu_ctrl, mdu_srca, mdu_srcb, pend_valid, op_done, err_timeout, stall, dbg_state} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got start=%b ctrl=%0d a=%h b=%h pend=%b done=%b err=%b stall=%b st=%0d, expected all 0",
               mdu_start, mdu_ctrl, mdu_srca, mdu_srcb, pend_valid, op_done, err_timeout, stall, dbg_state);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_mult();
    int w, base_d, done_k, stall_seen;
    base_d = dones; done_k = -1; stall_seen = 0;
    send_op(3'd0, 32'hFFFF_FFFE, 32'd3, w);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk); #1;
      if (stall !== 1'b0) stall_seen++;
      if (k == 0) begin
        tests++;
        if (mdu_start !== 1'b1 || dbg_state !== 2'd1) begin
          fails++;
          $display("FAIL mult_issue got start=%b st=%0d, expected start=1 st=1", mdu_start, dbg_state);
        end
      end
      if (op_done === 1'b1 && done_k < 0) begin
        done_k = k;
        tests++;
        if (dbg_state !== 2'd0) begin
          fails++;
          $display("FAIL mult_idle got st=%0d, expected 0", dbg_state);
        end
      end
    end
    tests++;
    if (done_k != MULT_CYCLES + 2) begin
      fails++;
      $display("FAIL mult_latency got op_done at %0d, expected %0d", done_k, MULT_CYCLES + 2);
    end
    tests++;
    if (dones - base_d != 1) begin
      fails++;
      $display("FAIL mult_done_count got %0d, expected 1", dones - base_d);
    end
    tests++;
    if (stall_seen != 0 || w != 0) begin
      fails++;
      $display("FAIL mult_stall got %0d stall cycles, expected 0", stall_seen + w);
    end
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      fails++;
      $display("FAIL mult_result got %h, expected ffffffff_fffffffa", {hi, lo});
    end
  endtask

  task automatic test_div_mfhi();
    int w, n, base_d;
    base_d = dones; n = 0;
    send_op(3'd2, 32'd100, 32'd7, w);
    @(negedge clk);
    rd_hilo = 1'b1;
    #1;
    while (stall === 1'b1 && n < 60) begin
      n++;
      @(negedge clk); #1;
    end
    tests++;
    if (n != DIV_CYCLES + 2) begin
      fails++;
      $display("FAIL div_mfhi_stall got %0d cycles, expected %0d", n, DIV_CYCLES + 2);
    end
    tests++;
    if (op_done !== 1'b1 || dones - base_d != 1) begin
      fails++;
      $display("FAIL div_done got op_done=%b count=%0d, expected 1 and 1", op_done, dones - base_d);
    end
    tests++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      fails++;
      $display("FAIL div_hilo got hi=%0d lo=%0d, expected hi=2 lo=14", hi, lo);
    end
    @(posedge clk); #1;
    rd_hilo = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w1, w2, w3, base_d;
    start_cyc_q.delete(); done_cyc_q.delete();
    base_d = dones;
    send_op(3'd0, 32'd7, 32'd6, w1);
    send_op(3'd2, 32'd50, 32'd5, w2);
    @(negedge clk); #1;
    tests++;
    if (pend_valid !== 1'b1 || w2 != 0) begin
      fails++;
      $display("FAIL b2b_buffered got pend=%b wait=%0d, expected pend=1 wait=0", pend_valid, w2);
    end
    send_op(3'd1, 32'd3, 32'd4, w3);
    tests++;
    if (w3 == 0) begin
      fails++;
      $display("FAIL b2b_third_stall got %0d stall cycles, expected >0", w3);
    end
    for (int k = 0; k < 100 && dones < base_d + 3; k++) begin
      @(negedge clk); #1;
    end
    tests++;
    if (dones - base_d != 3) begin
      fails++;
      $display("FAIL b2b_done_count got %0d, expected 3", dones - base_d);
    end
    tests++;
    if (start_cyc_q.size() != 3 || done_cyc_q.size() < 1) begin
      fails++;
      $display("FAIL b2b_start_count got %0d starts, expected 3", start_cyc_q.size());
    end else if (start_cyc_q[1] != done_cyc_q[0] || start_cyc_q[1] - start_cyc_q[0] != MULT_CYCLES + 2) begin
      fails++;
      $display("FAIL b2b_div_start got start at %0d (mult start %0d, done %0d), expected %0d",
               start_cyc_q[1], start_cyc_q[0], done_cyc_q[0], start_cyc_q[0] + MULT_CYCLES + 2);
    end
    tests++;
    if (lo !== 32'd12 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_final got lo=%0d pending_exp=%0d, expected lo=12 pending_exp=0", lo, exp_q.size());
    end
  endtask

  task automatic test_flush();
    int w, base_s, base_d;
    base_s = starts; base_d = dones;
    send_op(3'd0, 32'd9, 32'd9, w);
    send_op(3'd2, 32'd8, 32'd2, w);
    @(negedge clk);
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (pend_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_pend got pend=%b, expected 0", pend_valid);
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk); #1;
    end
    tests++;
    if (dones - base_d != 1 || lo !== 32'd81) begin
      fails++;
      $display("FAIL flush_mult_done got dones=%0d lo=%0d, expected 1 and 81", dones - base_d, lo);
    end
    tests++;
    if (starts - base_s != 1 || dbg_state !== 2'd0) begin
      fails++;
      $display("FAIL flush_no_div_start got starts=%0d st=%0d, expected 1 and 0", starts - base_s, dbg_state);
    end
  endtask

  task automatic test_mtlo();
    int w, n, base_d;
    base_d = dones; n = 0;
    send_op(3'd4, 32'h0000_1234, 32'd0, w);
    @(negedge clk);
    rd_hilo = 1'b1;
    #1;
    tests++;
    if (mdu_start !== 1'b1 || dbg_state !== 2'd1 || stall !== 1'b1) begin
      fails++;
      $display("FAIL mtlo_issue got start=%b st=%0d stall=%b, expected 1 1 1", mdu_start, dbg_state, stall);
    end
    while (stall === 1'b1 && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    tests++;
    if (n != 1 || dbg_state !== 2'd0 || lo !== 32'h1234) begin
      fails++;
      $display("FAIL mtlo_mflo got stall_cycles=%0d st=%0d lo=%h, expected 1 0 1234", n, dbg_state, lo);
    end
    @(posedge clk); #1;
    rd_hilo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
    end
    tests++;
    if (dones != base_d) begin
      fails++;
      $display("FAIL mtlo_no_done got %0d pulses, expected 0", dones - base_d);
    end
  endtask

  task automatic test_random();
    int w, base_d, n_md;
    logic [2:0] op;
    base_d = dones; n_md = 0;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 5));
      if (op <= 3'd3) n_md++;
      send_op(op, $urandom, 32'($urandom_range(1, 500)), w);
      for (int g = $urandom_range(0, 3); g > 0; g--) @(negedge clk);
    end
    for (int k = 0; k < 400 && !(dones - base_d == n_md && exp_q.size() == 0 && dbg_state == 2'd0); k++) begin
      @(negedge clk); #1;
    end
    tests++;
    if (dones - base_d != n_md || exp_q.size() != 0) begin
      fails++;
      $display("FAIL random_drain got dones=%0d pending_exp=%0d, expected %0d and 0", dones - base_d, exp_q.size(), n_md);
    end
    tests++;
    if (pend_valid !== 1'b0 || dbg_state !== 2'd0 || err_timeout !== 1'b0) begin
      fails++;
      $display("FAIL random_idle got pend=%b st=%0d err=%b, expected 0 0 0", pend_valid, dbg_state, err_timeout);
    end
  endtask

  task automatic test_timeout_reset();
    int w, bad;
    logic exp_err;
    bad = 0;
    send_op(3'd0, 32'd1, 32'd2, w);
    force_busy = 1'b1;
    @(negedge clk); #1;
    // RUN cycles numbered from 1: the counter (loaded with 9) reaches zero
    // at the end of RUN cycle 9, so the flag shows from RUN cycle 10 on.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      exp_err = (k >= 10);
      tests++;
      if (err_timeout !== exp_err || dbg_state !== 2'd2) begin
        fails++; bad++;
        if (bad < 4)
          $display("FAIL timeout_err run_cycle=%0d got err=%b st=%0d, expected err=%b st=2", k, err_timeout, dbg_state, exp_err);
      end
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    force_busy = 1'b0;
    #1;
    tests++;
    if ({mdu_start, mdu_ctrl, mdu_srca, mdu_srcb, pend_valid, op_done, err_timeout, stall, dbg_state} !== '0) begin
      fails++;
      $display("FAIL async_reset got start=%b ctrl=%0d a=%h b=%h pend=%b done=%b err=%b st=%0d, expected all 0",
               mdu_start, mdu_ctrl, mdu_srca, mdu_srcb, pend_valid, op_done, err_timeout, dbg_state);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (err_timeout !== 1'b0 || dbg_state !== 2'd0) begin
      fails++;
      $display("FAIL post_reset got err=%b st=%0d, expected 0 0", err_timeout, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_mfhi();
    test_back_to_back();
    test_flush();
    test_mtlo();
    test_random();
    test_timeout_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
